// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    function automatic logic [31:0] lane_mask(size_t sz);
        case (sz)
            SZ_BYTE: return MASK_BYTE;
            SZ_HALF: return MASK_HALF;
            default: return MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and data-memory bus of the load/store sequencer.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [31:0]       mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data,
        output mem_write_enable, mem_read_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data,
        input  mem_write_enable, mem_read_enable
    );

endinterface

// File: rtl/lsu_align.sv
// Little-endian lane extract/extend for loads and lane merge for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  size_t       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [4:0]  w_shamt;
    logic [31:0] w_shift;
    logic [31:0] w_mask;
    logic        w_sext;

    assign w_shamt = {i_lane, 3'b000};
    assign w_shift = i_old >> w_shamt;
    assign w_mask  = lane_mask(i_size) << w_shamt;
    assign o_merge = (i_old & ~w_mask) | ((i_new << w_shamt) & w_mask);

    always_comb begin
        o_load = w_shift;
        w_sext = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                w_sext = ~i_unsigned & w_shift[7];
                o_load = {{24{w_sext}}, w_shift[7:0]};
            end
            SZ_HALF: begin
                w_sext = ~i_unsigned & w_shift[15];
                o_load = {{16{w_sext}}, w_shift[15:0]};
            end
            default: o_load = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: validates requests, drives registered memory
// enable pulses, performs sub-word read-modify-write and load extension.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input logic       clk,
    input logic       reset,
    lsu_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic              r_rd_en;
    logic              r_wr_en;
    logic              r_resp_valid;
    logic              r_resp_error;
    logic [31:0]       r_resp_rdata;
    logic [31:0]       r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_write;
    logic              r_unsigned;
    size_t             r_size;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata;
    size_t             w_size;
    logic [ADDR_W-1:0] w_idx;
    logic              w_accept;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    assign w_size   = size_t'(bus.req_size);
    assign w_idx    = bus.req_addr >> 2;
    assign w_accept = bus.req_valid && r_ready;
    assign w_err    = (w_size == SZ_ILL)
                   || (w_size == SZ_HALF && bus.req_addr[0])
                   || (w_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                   || (w_idx >= ADDR_W'(DEPTH));

    lsu_align u_align (
        .i_size     (r_size),
        .i_lane     (r_lane),
        .i_unsigned (r_unsigned),
        .i_old      (bus.mem_read_data),
        .i_new      (r_wdata),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err)                 w_next = RESP;
                    else if (!bus.req_write)   w_next = RD;
                    else if (w_size == SZ_WORD) w_next = WR;
                    else                       w_next = RD;
                end
            end
            RD:      w_next = CAP;
            CAP:     w_next = r_write ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake and enables are registered from the next state so the
    // memory only ever sees flop outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready      <= 1'b1;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_wdata  <= '0;
            r_mem_addr   <= '0;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= SZ_BYTE;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
        end else begin
            r_ready      <= (w_next == IDLE);
            r_rd_en      <= (w_next == RD);
            r_wr_en      <= (w_next == WR);
            r_resp_valid <= (w_next == RESP);
            if (w_accept) begin
                r_mem_addr <= w_idx;
                r_write    <= bus.req_write;
                r_unsigned <= bus.req_unsigned;
                r_size     <= w_size;
                r_lane     <= bus.req_addr[1:0];
                r_wdata    <= bus.req_wdata;
                if (w_size == SZ_WORD) r_mem_wdata <= bus.req_wdata;
            end
            if (r_state == CAP && r_write) r_mem_wdata <= w_merge;
            if (w_next == RESP) begin
                r_resp_error <= (r_state == IDLE);
                r_resp_rdata <= (r_state == CAP && !r_write) ? w_load : '0;
            end
        end
    end

    assign bus.req_ready        = r_ready;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_rdata       = r_resp_rdata;
    assign bus.resp_error       = r_resp_error;
    assign bus.mem_address      = r_mem_addr;
    assign bus.mem_write_data   = r_mem_wdata;
    assign bus.mem_write_enable = r_wr_en;
    assign bus.mem_read_enable  = r_rd_en;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl against a byte-array memory model.
module tb_lsu_ctrl;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          n_rd;
        int          n_wr;
        logic [31:0] idx;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    exp_t        me;
    logic [31:0] mem [DEPTH];
    logic [7:0]  refb [4*DEPTH];
    logic        prev_en = 1'b0;
    logic        prev_rv = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;

    lsu_ctrl_if #(.ADDR_W(32)) bus();

    lsu_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: registered read, write on enable.
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] = {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]};
        end
        if (bus.mem_read_enable && bus.mem_address < DEPTH)
            bus.mem_read_data <= mem[bus.mem_address];
        if (bus.mem_write_enable && bus.mem_address < DEPTH)
            mem[bus.mem_address] = bus.mem_write_data;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(bit w, bit [1:0] sz, bit u,
                                   logic [31:0] a, logic [31:0] d);
        exp_t        e;
        int          n;
        logic [31:0] idx;
        logic [31:0] v;
        e = '{rdata: 0, err: 0, lat: 0, acc: 0, n_rd: 0, n_wr: 0,
              idx: 0, wdata: 0};
        idx = a >> 2;
        e.idx = idx;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (a % n) != 0 || idx >= DEPTH) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        if (w) begin
            for (int k = 0; k < n; k++) refb[a+k] = d[8*k +: 8];
            for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = refb[4*idx+k];
            e.n_wr = 1;
            e.n_rd = (n == 4) ? 0 : 1;
            e.lat  = (n == 4) ? 2 : 4;
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = refb[a+k];
            if (n < 4 && !u && v[8*n-1])
                for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            e.rdata = v;
            e.n_rd  = 1;
            e.lat   = 3;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        bus.req_valid = 1'b0;
        repeat (k) step();
    endtask

    // Leaves req_valid high; callers either idle or issue again back-to-back.
    task automatic issue(bit w, bit [1:0] sz, bit u,
                         logic [31:0] a, logic [31:0] d);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        chk("sb_empty_at_accept", 32'(sb.size()), 32'd0);
        e = model(w, sz, u, a, d);
        e.acc = cyc + 1;
        sb.push_back(e);
        step();
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_en = 1'b0;
            prev_rv = 1'b0;
            n_rd = 0;
            n_wr = 0;
        end else begin
            if (bus.mem_read_enable || bus.mem_write_enable) begin
                chk("en_overlap",
                    {31'd0, bus.mem_read_enable & bus.mem_write_enable}, 32'd0);
                chk("en_gap", {31'd0, prev_en}, 32'd0);
                if (sb.size() == 0) begin
                    chk("stray_pulse",
                        {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
                end else begin
                    chk("mem_address", bus.mem_address, sb[0].idx);
                    if (bus.mem_write_enable)
                        chk("mem_write_data", bus.mem_write_data, sb[0].wdata);
                end
                n_rd += int'(bus.mem_read_enable);
                n_wr += int'(bus.mem_write_enable);
            end
            prev_en = bus.mem_read_enable | bus.mem_write_enable;
            if (bus.resp_valid) begin
                chk("resp_pulse", {31'd0, prev_rv}, 32'd0);
                if (sb.size() == 0) begin
                    chk("stray_resp", {31'd0, bus.resp_valid}, 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("resp_rdata", bus.resp_rdata, me.rdata);
                    chk("resp_error", {31'd0, bus.resp_error}, {31'd0, me.err});
                    chk("latency", 32'(cyc - me.acc + 1), 32'(me.lat));
                    chk("read_pulses", 32'(n_rd), 32'(me.n_rd));
                    chk("write_pulses", 32'(n_wr), 32'(me.n_wr));
                end
                n_rd = 0;
                n_wr = 0;
            end
            prev_rv = bus.resp_valid;
        end
    end

    initial begin
        logic [31:0] w0;
        logic [7:0]  sav [4];
        logic [31:0] a;
        bit          w;
        bit          u;
        bit [1:0]    sz;
        int          r;
        int          n;

        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w0 = $urandom;
            for (int k = 0; k < 4; k++) refb[4*i+k] = w0[8*k +: 8];
        end

        repeat (3) step();
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_rd_en", {31'd0, bus.mem_read_enable}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.mem_write_enable}, 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        reset = 1'b0;
        step();

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        idle(2);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle(2);
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        idle(3);
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h8000FF80);
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h3, 32'h1234);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h55AA55AA);
        idle(3);

        // Abort an RMW store while it sits in CAP.
        for (int k = 0; k < 4; k++) sav[k] = refb[20+k];
        issue(1'b1, 2'd0, 1'b0, 32'h15, 32'h0000005A);
        bus.req_valid = 1'b0;
        step();
        reset = 1'b1;
        sb.delete();
        for (int k = 0; k < 4; k++) refb[20+k] = sav[k];
        step();
        reset = 1'b0;
        step();
        chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
        idle(4);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
        idle(2);

        for (int t = 0; t < 150; t++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 9);
            if (r < 8)       a = $urandom_range(0, 63);
            else if (r == 8) a = 32'h0FF0 + $urandom_range(0, 31);
            else             a = $urandom;
            issue(w, sz, u, a, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        bus.req_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            step();
            n++;
        end
        if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 16; i++)
            chk("mem_word", mem[i],
                {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]});
        for (int i = DEPTH - 8; i < DEPTH; i++)
            chk("mem_word_top", mem[i],
                {refb[4*i+3], refb[4*i+2], refb[4*i+1], refb[4*i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer directly upstream of the word-addressed data memory; the memory's read/write enables are edge-triggered.
- Accepts byte-addressed byte/half/word requests from the core via a valid/ready handshake.
- Drives single-cycle glitch-free enable pulses to the memory.
- Performs read-modify-write for sub-word stores and sign/zero-extends loads, returning one response per request.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; word index ≥ DEPTH is out of range.
- ADDR_W, 32, width of byte address and memory address ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (IDLE only)
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_error  out  1  misaligned, illegal size or out-of-range; qualified by resp_valid
- mem_address  out  ADDR_W  word index = req_addr >> 2
- mem_write_data  out  32  merged word to store
- mem_write_enable  out  1  write pulse
- mem_read_enable  out  1  read pulse
- mem_read_data  in  32  memory read result

Behaviour:
- Reset:
  - state IDLE.
  - req_ready=1; resp_valid=0; resp_error=0; resp_rdata=0.
  - mem_read_enable=0; mem_write_enable=0; mem_address=0; mem_write_data=0.
- Enables are driven directly from flops, never combinational decode. Each pulse is exactly one cycle high. Enables are never high together. Every pulse is followed by at least one low cycle.
- Handshake:
  - A request is accepted on a clk edge with req_valid && req_ready; all request fields are latched.
  - req_ready=0 in every state except IDLE.
  - The requester holds its request while req_ready=0; it is ignored until IDLE.
- Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]≠0; (addr>>2) ≥ DEPTH.
  - Any failure → RESP with resp_error=1, resp_rdata=0, no memory access.
- States:
  - IDLE: on accept → ERR path to RESP; load → RD; word store → WR; byte/half store → RD (RMW).
  - RD: mem_read_enable=1, mem_address=word index → CAP.
  - CAP: enables 0; capture mem_read_data. Load → RESP. RMW → merge lane(s) → WR.
  - WR: mem_write_enable=1, mem_write_data=merged or full word → RESP.
  - RESP: resp_valid=1 for one cycle → IDLE. req_ready returns to 1 the cycle after RESP.
- Latency (cycles from accept edge to resp_valid high):
  - error 1
  - word store 2
  - load 3
  - sub-word store 4
- Lanes (little-endian):
  - Byte lane = addr[1:0]; half lane = addr[1] (bits [15:0] or [31:16]).
  - Loads extract the lane to bit 0, then extend per req_unsigned.
  - Stores replace only the lane bytes of the captured word.
- resp_rdata and resp_error hold their last value outside RESP; only resp_valid qualifies them.
- Reset mid-operation: next edge forces IDLE, enables 0, no response issued. A write pulse already issued is not retracted.

Decomposition:
- Package lsu_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - state_t enum (IDLE, RD, CAP, WR, RESP)
  - lane/byte-enable helper constants
- One combinational sub-module, lsu_align: load extract/extend and store merge given size, addr[1:0], unsigned flag, old word, new data.

Test Plan:
- Word store then load: store addr 0x10 data 0xDEADBEEF.
  - Required: mem_address=4, one write pulse, resp_valid at +2.
  - Load 0x10 → resp_rdata=0xDEADBEEF at +3, resp_error=0.
- Byte store RMW: word 4 = 0x11223344; store byte 0xAA at addr 0x12.
  - Required: read pulse, then write pulse with 0x11AA3344, resp at +4.
- Load extension on word 0x8000FF80:
  - byte signed addr 0 → 0xFFFFFF80
  - byte unsigned → 0x00000080
  - half signed addr 2 → 0xFFFF8000
  - half unsigned addr 0 → 0x0000FF80
- Errors:
  - half at 0x3 → resp_error=1 at +1, no enable pulse.
  - word at 0x1000 (index 1024, DEPTH=1024) → same.
- Back-to-back requests with req_valid held high: second accepted only after RESP. Enables never overlap; a low gap separates pulses.
- Reset asserted during CAP of an RMW store: no write pulse, no resp_valid; req_ready=1 the cycle after reset deasserts.
